prbs_checker: RTL and testbench

PRBS_CHECKER -- requirements
Module: prbs_checker

---
 rtl/prbs_pkg.sv | 20 ++
 rtl/prbs_checker.sv | 124 ++++++++++++
 tb/tb_prbs_checker.sv | 254 +++++++++++++++++++++++++
 3 files changed

// File: rtl/prbs_pkg.sv
// Shared PRBS-24 definitions: tap set, generator seed, checker state encoding
// and the single-step LFSR function used by both generator and checker.
package prbs_pkg;

  localparam int unsigned LFSR_W = 24;
  localparam logic [LFSR_W-1:0] TAP_MASK = 24'h80_000D;
  localparam logic [LFSR_W-1:0] SEED     = 24'h89_64CE;

  typedef enum logic [1:0] {
    ST_SEARCH = 2'd0,
    ST_VERIFY = 2'd1,
    ST_LOCKED = 2'd2
  } state_e;

  // Shift left, feedback bit is the parity of the tapped bits.
  function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] w);
    return {w[LFSR_W-2:0], ^(w & TAP_MASK)};
  endfunction

endpackage

// File: rtl/prbs_checker.sv
// PRBS-24 checker: search / verify / flywheel lock with error pulse and optional
// saturating error counter (enabled by defining PRBS_CHK_ERRCNT_EN).
module prbs_checker
  import prbs_pkg::*;
#(
  parameter int unsigned LOCK_CNT   = 4,
  parameter int unsigned UNLOCK_CNT = 3,
  parameter int unsigned CNT_W      = 16
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              valid_i,
  input  logic [LFSR_W-1:0] data_i,
  input  logic              clear_i,
  output logic              locked_o,
  output logic              err_o,
  output logic [CNT_W-1:0]  err_count_o
);

  localparam int unsigned RUN_W = 4;

  state_e            state_q, state_d;
  logic [LFSR_W-1:0] pred_q, pred_d;
  logic [RUN_W-1:0]  match_q, match_d;
  logic [RUN_W-1:0]  miss_q, miss_d;
  logic [RUN_W-1:0]  match_inc, miss_inc;
  logic              err_hit;

  assign match_inc = match_q + RUN_W'(1);
  assign miss_inc  = miss_q + RUN_W'(1);

  // Next-state and prediction logic; nothing moves without a valid word.
  always_comb begin
    state_d = state_q;
    pred_d  = pred_q;
    match_d = match_q;
    miss_d  = miss_q;
    err_hit = 1'b0;
    if (valid_i) begin
      unique case (state_q)
        ST_SEARCH: begin
          if (data_i != '0) begin
            pred_d  = lfsr_next(data_i);
            match_d = RUN_W'(1);
            state_d = ST_VERIFY;
          end
        end
        ST_VERIFY: begin
          if (data_i == pred_q) begin
            pred_d  = lfsr_next(data_i);
            match_d = match_inc;
            if (match_inc == RUN_W'(LOCK_CNT)) begin
              state_d = ST_LOCKED;
            end
          end else if (data_i == '0) begin
            pred_d  = '0;
            match_d = '0;
            state_d = ST_SEARCH;
          end else begin
            pred_d  = lfsr_next(data_i);
            match_d = RUN_W'(1);
          end
        end
        ST_LOCKED: begin
          // Flywheel: prediction advances from itself, not from the received word.
          pred_d = lfsr_next(pred_q);
          if (data_i != pred_q) begin
            err_hit = 1'b1;
            if (miss_inc == RUN_W'(UNLOCK_CNT)) begin
              miss_d  = '0;
              match_d = '0;
              state_d = ST_SEARCH;
            end else begin
              miss_d = miss_inc;
            end
          end else begin
            miss_d = '0;
          end
        end
        default: state_d = ST_SEARCH;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= ST_SEARCH;
      pred_q   <= '0;
      match_q  <= '0;
      miss_q   <= '0;
      locked_o <= 1'b0;
      err_o    <= 1'b0;
    end else begin
      state_q  <= state_d;
      pred_q   <= pred_d;
      match_q  <= match_d;
      miss_q   <= miss_d;
      locked_o <= (state_d == ST_LOCKED);
      err_o    <= err_hit;
    end
  end

`ifdef PRBS_CHK_ERRCNT_EN
  logic [CNT_W-1:0] err_cnt_q;

  // Clear has priority over a coincident error; count sticks at all-ones.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      err_cnt_q <= '0;
    end else if (clear_i) begin
      err_cnt_q <= '0;
    end else if (err_hit && (err_cnt_q != '1)) begin
      err_cnt_q <= err_cnt_q + CNT_W'(1);
    end
  end

  assign err_count_o = err_cnt_q;
`else
  logic unused_clear;
  assign unused_clear = clear_i;
  assign err_count_o  = '0;
`endif

endmodule

// File: tb/tb_prbs_checker.sv
// Randomized self-checking bench for prbs_checker against a word-level reference model.
module tb_prbs_checker;

  localparam int unsigned LOCK   = 4;
  localparam int unsigned UNLOCK = 3;
  localparam int unsigned CNT_W  = 4;
  localparam int          CNT_MAX = (1 << CNT_W) - 1;
`ifdef PRBS_CHK_ERRCNT_EN
  localparam bit ERRCNT_EN = 1'b1;
`else
  localparam bit ERRCNT_EN = 1'b0;
`endif

  logic             clk_i = 1'b0;
  logic             rst_ni;
  logic             valid_i;
  logic [23:0]      data_i;
  logic             clear_i;
  logic             locked_o;
  logic             err_o;
  logic [CNT_W-1:0] err_count_o;

  prbs_checker #(.LOCK_CNT(LOCK), .UNLOCK_CNT(UNLOCK), .CNT_W(CNT_W)) dut (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .valid_i     (valid_i),
    .data_i      (data_i),
    .clear_i     (clear_i),
    .locked_o    (locked_o),
    .err_o       (err_o),
    .err_count_o (err_count_o)
  );

  always #5 clk_i = ~clk_i;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic bit [23:0] gen_next(input bit [23:0] w);
    bit fb;
    fb = w[23] ^ w[3] ^ w[2] ^ w[0];
    return {w[22:0], fb};
  endfunction

  // Reference model: mode 0 = hunting, 1 = confirming run, 2 = locked.
  int       m_mode;
  bit [23:0] m_pred;
  int       m_run, m_miss, m_cnt;
  bit       m_err, m_lock;

  function automatic logic [31:0] exp_cnt();
    return ERRCNT_EN ? 32'(m_cnt) : 32'd0;
  endfunction

  task automatic model_reset();
    m_mode = 0; m_pred = '0; m_run = 0; m_miss = 0; m_cnt = 0; m_err = 0; m_lock = 0;
  endtask

  task automatic model_step(input bit v, input bit [23:0] d, input bit c);
    bit hit;
    m_err = 0;
    if (v) begin
      if (m_mode == 0) begin
        if (d != 0) begin m_pred = gen_next(d); m_run = 1; m_mode = 1; end
      end else if (m_mode == 1) begin
        if (d == m_pred) begin
          m_run++; m_pred = gen_next(d);
          if (m_run >= LOCK) m_mode = 2;
        end else if (d == 0) begin
          m_mode = 0; m_run = 0;
        end else begin
          m_run = 1; m_pred = gen_next(d);
        end
      end else begin
        hit = (d != m_pred);
        m_pred = gen_next(m_pred);
        if (hit) begin
          m_err = 1; m_miss++;
          if (m_cnt < CNT_MAX) m_cnt++;
          if (m_miss == UNLOCK) begin m_mode = 0; m_miss = 0; m_run = 0; end
        end else begin
          m_miss = 0;
        end
      end
    end
    if (c) m_cnt = 0;
    m_lock = (m_mode == 2);
  endtask

  task automatic step(input bit v, input bit [23:0] d, input bit c);
    @(negedge clk_i);
    valid_i = v; data_i = d; clear_i = c;
    @(posedge clk_i);
    model_step(v, d, c);
    #1;
    check("locked", 32'(locked_o), 32'(m_lock));
    check("err", 32'(err_o), 32'(m_err));
    check("err_count", 32'(err_count_o), exp_cnt());
  endtask

  bit [23:0] gw;

  task automatic send_good(input bit c);
    step(1'b1, gw, c);
    gw = gen_next(gw);
  endtask

  task automatic send_bad(input bit c);
    bit [23:0] r;
    r = 24'($urandom);
    if (r == gw) r ^= 24'h1;
    step(1'b1, r, c);
    gw = gen_next(gw);
  endtask

  task automatic quiet();
    @(negedge clk_i);
    valid_i = 1'b0; clear_i = 1'b0;
  endtask

  task automatic async_reset();
    quiet();
    @(posedge clk_i);
    #2;
    rst_ni = 1'b0;
    #1;
    check("rst_locked", 32'(locked_o), 32'd0);
    check("rst_err", 32'(err_o), 32'd0);
    check("rst_count", 32'(err_count_o), 32'd0);
    model_reset();
    @(negedge clk_i);
    rst_ni = 1'b1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_ni = 1'b0; valid_i = 1'b0; data_i = '0; clear_i = 1'b0;
    model_reset();
    repeat (3) @(posedge clk_i);
    #1;
    check("reset_locked", 32'(locked_o), 32'd0);
    check("reset_err", 32'(err_o), 32'd0);
    check("reset_count", 32'(err_count_o), 32'd0);
    @(negedge clk_i);
    rst_ni = 1'b1;

    // Clean stream from the generator seed: lock on the 4th word, no errors.
    gw = 24'h89_64CE;
    repeat (3) send_good(1'b0);
    check("lock_after_3", 32'(locked_o), 32'd0);
    send_good(1'b0);
    check("lock_after_4", 32'(locked_o), 32'd1);
    repeat (9996) send_good(1'b0);
    check("clean_locked", 32'(locked_o), 32'd1);
    check("clean_count", 32'(err_count_o), 32'd0);

    // Single bit-5 flip while locked.
    step(1'b1, gw ^ 24'h20, 1'b0);
    gw = gen_next(gw);
    check("flip_err", 32'(err_o), 32'd1);
    check("flip_lock", 32'(locked_o), 32'd1);
    check("flip_count", 32'(err_count_o), ERRCNT_EN ? 32'd1 : 32'd0);
    repeat (5) send_good(1'b0);
    check("flip_after_err", 32'(err_o), 32'd0);

    // Three consecutive bad words drop lock; stream relocks after 4 words.
    send_good(1'b1);
    repeat (2) send_bad(1'b0);
    check("burst_still_locked", 32'(locked_o), 32'd1);
    send_bad(1'b0);
    check("burst_unlock", 32'(locked_o), 32'd0);
    check("burst_count", 32'(err_count_o), ERRCNT_EN ? 32'd3 : 32'd0);
    repeat (3) send_good(1'b0);
    check("relock_3", 32'(locked_o), 32'd0);
    send_good(1'b0);
    check("relock_4", 32'(locked_o), 32'd1);
    check("relock_count_held", 32'(err_count_o), ERRCNT_EN ? 32'd3 : 32'd0);

    // Alternating valid: lock timing counted in valid beats only.
    async_reset();
    gw = 24'h89_64CE;
    for (int b = 0; b < 4; b++) begin
      check("alt_pre_lock", 32'(locked_o), 32'd0);
      send_good(1'b0);
      step(1'b0, 24'($urandom), 1'b0);
    end
    check("alt_lock", 32'(locked_o), 32'd1);
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(1) == 1) send_good(1'b0);
      else step(1'b0, 24'($urandom), 1'b0);
    end
    check("alt_count", 32'(err_count_o), 32'd0);

    // Lockup words never leave SEARCH; async reset while locked.
    async_reset();
    repeat (20) step(1'b1, 24'h0, 1'b0);
    check("zero_search", 32'(locked_o), 32'd0);
    repeat (6) send_good(1'b0);
    send_bad(1'b0);
    send_good(1'b0);
    check("pre_rst_locked", 32'(locked_o), 32'd1);
    async_reset();

    // Saturate the counter with isolated errors, then clear against an error.
    repeat (5) send_good(1'b0);
    for (int i = 0; i < CNT_MAX + 3; i++) begin
      send_bad(1'b0);
      send_good(1'b0);
    end
    check("sat_value", 32'(err_count_o), ERRCNT_EN ? 32'(CNT_MAX) : 32'd0);
    send_bad(1'b0);
    check("sat_hold", 32'(err_count_o), ERRCNT_EN ? 32'(CNT_MAX) : 32'd0);
    send_good(1'b0);
    send_bad(1'b1);
    check("clear_wins_err", 32'(err_o), 32'd1);
    check("clear_wins_count", 32'(err_count_o), 32'd0);

    // Random mix of valid gaps, bit flips, garbage, lockup words and clears.
    for (int i = 0; i < 3000; i++) begin
      int unsigned r;
      r = $urandom_range(99);
      if (r < 20) begin
        step(1'b0, 24'($urandom), 1'b0);
      end else if (r < 26) begin
        step(1'b1, gw ^ (24'h1 << $urandom_range(23)), ($urandom_range(9) == 0));
        gw = gen_next(gw);
      end else if (r < 29) begin
        send_bad(1'b0);
      end else if (r < 30) begin
        step(1'b1, 24'h0, 1'b0);
        gw = gen_next(gw);
      end else begin
        send_good($urandom_range(49) == 0);
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
